// File: rtl/usb1_dev_sie.sv
// usb1_dev_sie: USB 1.1 full-speed device serial interface engine (receive and handshake side).
//
// Decodes SOF/OUT/SETUP/IN tokens and DATA0/DATA1 packets arriving on the UTMI receive port.
// It checks PID, CRC5, CRC16, address and length, streams validated OUT/SETUP payload bytes to
// the endpoint logic, and answers good data packets with an ACK or NAK on the UTMI transmit port.
//
// Ports:
//   usb_clk_i, usb_rst_i           clock (60 MHz) and asynchronous active-high reset
//   dev_addr_i                     assigned device address
//   ep_rdy_i                       endpoint OUT buffer ready (0 -> NAK on OUT)
//   utmi_data_in_i/rxvalid/rxactive/rxerror   UTMI receive port
//   utmi_txready_i, utmi_data_out_o, utmi_txvalid_o   UTMI transmit port (handshakes only)
//   sof_o, frame_num_o             SOF pulse and last valid frame number
//   tok_o, tok_pid_o, tok_ep_o     address-matched OUT/SETUP/IN token pulse, PID and endpoint
//   rx_data_o, rx_valid_o          payload byte stream
//   rx_done_o, rx_err_o, rx_data1_o   end-of-packet status and data toggle of that packet
module usb1_dev_sie #(
    parameter int unsigned MAX_PKT   = 64,
    parameter int unsigned TA_CYCLES = 16
) (
    input  logic        usb_clk_i,
    input  logic        usb_rst_i,
    input  logic [6:0]  dev_addr_i,
    input  logic        ep_rdy_i,
    input  logic [7:0]  utmi_data_in_i,
    input  logic        utmi_rxvalid_i,
    input  logic        utmi_rxactive_i,
    input  logic        utmi_rxerror_i,
    input  logic        utmi_txready_i,
    output logic [7:0]  utmi_data_out_o,
    output logic        utmi_txvalid_o,
    output logic        sof_o,
    output logic [10:0] frame_num_o,
    output logic        tok_o,
    output logic [3:0]  tok_pid_o,
    output logic [3:0]  tok_ep_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        rx_done_o,
    output logic        rx_err_o,
    output logic        rx_data1_o
);

    localparam int unsigned CntW = $clog2(MAX_PKT + 3) + 1;
    localparam int unsigned TaW  = $clog2(TA_CYCLES + 1);
    // Byte index at which the payload byte being released would exceed MAX_PKT.
    localparam logic [CntW-1:0] LenLimit = CntW'(MAX_PKT + 2);
    localparam logic [TaW-1:0]  TaLast   = TaW'(TA_CYCLES - 1);

    localparam logic [3:0] PidOut   = 4'h1;
    localparam logic [3:0] PidIn    = 4'h9;
    localparam logic [3:0] PidSetup = 4'hD;
    localparam logic [3:0] PidSof   = 4'h5;
    localparam logic [3:0] PidData0 = 4'h3;
    localparam logic [3:0] PidData1 = 4'hB;

    localparam logic [7:0] HsAck = 8'hD2;
    localparam logic [7:0] HsNak = 8'h5A;

    typedef enum logic [2:0] {StIdle, StPid, StToken, StData, StTa, StHs, StIgnore} state_e;

    // Serial CRC, LSB of each byte first, register shifted towards its MSB.
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (d[i] ^ r[4]) r = {r[3:0], 1'b0} ^ 5'b00101;
            else             r = {r[3:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (d[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    state_e          state_q;
    logic [3:0]      pid_q;
    logic            armed_q;
    logic            setup_q;
    logic            tok_arm_q;   // current token is the one that armed the block
    logic            err_pend_q;  // rxerror seen in DATA, report at end of packet
    logic [1:0]      tok_cnt_q;
    logic [7:0]      tok_b0_q;
    logic [4:0]      crc5_q;
    logic [15:0]     crc16_q;
    logic [CntW-1:0] byte_cnt_q;
    logic            len_err_q;
    logic [7:0]      hold0_q;
    logic [7:0]      hold1_q;
    logic [TaW-1:0]  ta_cnt_q;

    logic            sof_q;
    logic [10:0]     frame_q;
    logic            tok_q;
    logic [3:0]      tok_pid_q;
    logic [3:0]      tok_ep_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            rx_done_q;
    logic            rx_err_q;
    logic            data1_q;
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;

    logic [3:0]  pid_lo;
    logic        pid_ok;
    logic        is_token;
    logic        is_data;
    logic [4:0]  crc5_d;
    logic [15:0] crc16_d;
    logic        data_good;

    always_comb begin
        pid_lo    = utmi_data_in_i[3:0];
        pid_ok    = (utmi_data_in_i[7:4] == ~pid_lo);
        is_token  = (pid_lo == PidOut) || (pid_lo == PidIn) ||
                    (pid_lo == PidSetup) || (pid_lo == PidSof);
        is_data   = (pid_lo == PidData0) || (pid_lo == PidData1);
        crc5_d    = crc5_byte(crc5_q, utmi_data_in_i);
        crc16_d   = crc16_byte(crc16_q, utmi_data_in_i);
        data_good = (byte_cnt_q >= CntW'(2)) && !len_err_q && (crc16_q == 16'h800D);
    end

    always_ff @(posedge usb_clk_i or posedge usb_rst_i) begin
        if (usb_rst_i) begin
            state_q    <= StIdle;
            pid_q      <= '0;
            armed_q    <= 1'b0;
            setup_q    <= 1'b0;
            tok_arm_q  <= 1'b0;
            err_pend_q <= 1'b0;
            tok_cnt_q  <= '0;
            tok_b0_q   <= '0;
            crc5_q     <= '1;
            crc16_q    <= '1;
            byte_cnt_q <= '0;
            len_err_q  <= 1'b0;
            hold0_q    <= '0;
            hold1_q    <= '0;
            ta_cnt_q   <= '0;
            sof_q      <= 1'b0;
            frame_q    <= '0;
            tok_q      <= 1'b0;
            tok_pid_q  <= '0;
            tok_ep_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
            data1_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            sof_q      <= 1'b0;
            tok_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (utmi_rxactive_i) begin
                        state_q    <= StPid;
                        err_pend_q <= 1'b0;
                    end
                end

                StPid: begin
                    if (utmi_rxerror_i) begin
                        state_q <= StIgnore;
                    end else if (!utmi_rxactive_i) begin
                        state_q <= StIdle;
                    end else if (utmi_rxvalid_i) begin
                        pid_q <= pid_lo;
                        if (!pid_ok) begin
                            state_q <= StIgnore;
                        end else if (is_token) begin
                            state_q   <= StToken;
                            tok_cnt_q <= '0;
                            tok_arm_q <= 1'b0;
                            crc5_q    <= '1;
                        end else if (is_data && armed_q) begin
                            state_q    <= StData;
                            byte_cnt_q <= '0;
                            len_err_q  <= 1'b0;
                            crc16_q    <= '1;
                            data1_q    <= (pid_lo == PidData1);
                        end else begin
                            state_q <= StIgnore;
                        end
                    end
                end

                StToken: begin
                    if (utmi_rxerror_i) begin
                        state_q <= StIgnore;
                    end else if (!utmi_rxactive_i) begin
                        state_q <= StIdle;
                    end else if (utmi_rxvalid_i) begin
                        crc5_q <= crc5_d;
                        if (tok_cnt_q == 2'd0) begin
                            tok_b0_q  <= utmi_data_in_i;
                            tok_cnt_q <= 2'd1;
                        end else if (tok_cnt_q == 2'd1) begin
                            tok_cnt_q <= 2'd2;
                            if (crc5_d == 5'b01100) begin
                                if (pid_q == PidSof) begin
                                    sof_q   <= 1'b1;
                                    frame_q <= {utmi_data_in_i[2:0], tok_b0_q};
                                end else if (tok_b0_q[6:0] == dev_addr_i) begin
                                    tok_q     <= 1'b1;
                                    tok_pid_q <= pid_q;
                                    tok_ep_q  <= {utmi_data_in_i[2:0], tok_b0_q[7]};
                                    armed_q   <= (pid_q != PidIn);
                                    tok_arm_q <= (pid_q != PidIn);
                                    setup_q   <= (pid_q == PidSetup);
                                end else begin
                                    armed_q <= 1'b0;
                                end
                            end
                        end else begin
                            // Over-long token: undo any arming it caused.
                            if (tok_arm_q) armed_q <= 1'b0;
                            state_q <= StIgnore;
                        end
                    end
                end

                StData: begin
                    if (utmi_rxerror_i) begin
                        state_q    <= StIgnore;
                        err_pend_q <= 1'b1;
                    end else if (!utmi_rxactive_i) begin
                        armed_q <= 1'b0;
                        if (data_good) begin
                            rx_done_q <= 1'b1;
                            state_q   <= StTa;
                            ta_cnt_q  <= '0;
                            tx_data_q <= (setup_q || ep_rdy_i) ? HsAck : HsNak;
                        end else begin
                            rx_err_q <= 1'b1;
                            state_q  <= StIdle;
                        end
                    end else if (utmi_rxvalid_i) begin
                        crc16_q <= crc16_d;
                        hold0_q <= hold1_q;
                        hold1_q <= utmi_data_in_i;
                        if (byte_cnt_q < LenLimit) byte_cnt_q <= byte_cnt_q + 1'b1;
                        // Release the byte two positions back so CRC bytes never leave.
                        if ((byte_cnt_q >= CntW'(2)) && !len_err_q) begin
                            if (byte_cnt_q >= LenLimit) begin
                                len_err_q <= 1'b1;
                            end else begin
                                rx_data_q  <= hold0_q;
                                rx_valid_q <= 1'b1;
                            end
                        end
                    end
                end

                StTa: begin
                    if (ta_cnt_q == TaLast) begin
                        tx_valid_q <= 1'b1;
                        state_q    <= StHs;
                    end else begin
                        ta_cnt_q <= ta_cnt_q + 1'b1;
                    end
                end

                StHs: begin
                    if (utmi_txready_i) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end

                StIgnore: begin
                    if (!utmi_rxactive_i) begin
                        state_q <= StIdle;
                        if (err_pend_q) begin
                            rx_err_q   <= 1'b1;
                            armed_q    <= 1'b0;
                            err_pend_q <= 1'b0;
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign utmi_data_out_o = tx_data_q;
    assign utmi_txvalid_o  = tx_valid_q;
    assign sof_o           = sof_q;
    assign frame_num_o     = frame_q;
    assign tok_o           = tok_q;
    assign tok_pid_o       = tok_pid_q;
    assign tok_ep_o        = tok_ep_q;
    assign rx_data_o       = rx_data_q;
    assign rx_valid_o      = rx_valid_q;
    assign rx_done_o       = rx_done_q;
    assign rx_err_o        = rx_err_q;
    assign rx_data1_o      = data1_q;

endmodule

// File: doc/usb1_dev_sie.md
# usb1_dev_sie

USB 1.1 full-speed device-side serial interface engine (receive/handshake half) on a UTMI interface: the function-end counterpart of the USB1.1 host controller. It decodes SOF/OUT/SETUP/IN tokens and DATA0/DATA1 packets from the FS PHY's UTMI receive port, and checks PID, CRC5, CRC16, address and length. Validated OUT/SETUP payload bytes are streamed to the endpoint logic, and the block replies with an ACK or NAK handshake on the UTMI transmit port. It sits between `usb_fs_phy` (device mode) and the device endpoint/register block, all in the `usb_clk_i` domain.

## Interface
- `MAX_PKT`, default 64: maximum data payload in bytes, excluding CRC.
- `TA_CYCLES`, default 16: `usb_clk_i` cycles from the end of a data packet to the handshake `utmi_txvalid_o` assertion.

- `usb_clk_i` in 1: the only clock, 60 MHz.
- `usb_rst_i` in 1: asynchronous, active-high reset.
- `dev_addr_i` in 7: assigned device address. Tokens are accepted only on an exact match; SOF ignores the address.
- `ep_rdy_i` in 1: endpoint OUT buffer ready. 0 causes a NAK on OUT; SETUP is always ACKed.
- `utmi_data_in_i` in 8, `utmi_rxvalid_i` in 1, `utmi_rxactive_i` in 1, `utmi_rxerror_i` in 1: UTMI receive port.
- `utmi_txready_i` in 1: UTMI transmit byte accept.
- `utmi_data_out_o` out 8, `utmi_txvalid_o` out 1: UTMI transmit port, used for handshakes only.
- `sof_o` out 1: one-cycle pulse on a valid SOF.
- `frame_num_o` out 11: frame number of the last valid SOF.
- `tok_o` out 1: one-cycle pulse on a valid, address-matched OUT/SETUP/IN token.
- `tok_pid_o` out 4: PID of that token.
- `tok_ep_o` out 4: endpoint of that token.
- `rx_data_o` out 8, `rx_valid_o` out 1: payload byte and its one-cycle strobe.
- `rx_done_o` out 1: pulse when a packet is good (CRC and length correct).
- `rx_err_o` out 1: pulse when a packet is bad (CRC, length, rxerror, or truncation).
- `rx_data1_o` out 1: PID of the last data packet was DATA1. Valid with `rx_done_o`.

## Operation
- PID byte: the first `utmi_rxvalid_i` byte after `utmi_rxactive_i` rises.
  - If `pid[7:4] != ~pid[3:0]`, go to IGNORE until `utmi_rxactive_i` falls.
- Token path (PIDs OUT 0x1, IN 0x9, SETUP 0xD, SOF 0x5):
  - Exactly 2 more bytes are collected; a third byte, or fewer than 2 bytes, discards the token.
  - CRC5: polynomial x^5+x^2+1, init 5'h1F, LSB-first over all 16 bits. A good token leaves residual 5'b01100; otherwise it is dropped silently.
  - SOF: `frame_num_o` is loaded and `sof_o` pulses.
  - OUT/SETUP with address match: arms the block, latching PID and endpoint. IN: pulses `tok_o` only; no response from this block.
- Data path (PIDs DATA0 0x3, DATA1 0xB):
  - Processed only when armed; otherwise go to IGNORE.
  - CRC16: polynomial x^16+x^15+x^2+1, init 16'hFFFF, LSB-first over payload plus received CRC. Good residual is 16'h800D.
  - Two-byte holding pipeline: a byte is emitted on `rx_valid_o` only when a third byte arrives, so the CRC bytes are never emitted.
  - Payload greater than `MAX_PKT` is an error and stops emission.
- End of packet (falling edge of `utmi_rxactive_i`):
  - Good packet: `rx_done_o` pulses, then the handshake is scheduled.
  - Bad packet: `rx_err_o` pulses, no handshake is sent, and the block disarms.
- Handshake: ACK (byte 8'hD2) if SETUP or `ep_rdy_i` is 1 at end of packet; otherwise NAK (byte 8'h5A).
- `utmi_rxerror_i` in any non-IDLE receive state goes to IGNORE. If in DATA, `rx_err_o` pulses at end of packet.
- States and transitions:
  - IDLE → PID on `utmi_rxactive_i`.
  - PID → TOKEN, DATA, or IGNORE.
  - TOKEN → IDLE.
  - DATA → TA (good) or IDLE (bad).
  - TA counts `TA_CYCLES` → HS.
  - HS → IDLE on `utmi_txready_i`.
  - IGNORE → IDLE when `utmi_rxactive_i` is low.
- A new token while armed re-arms or disarms according to the new token.
- `utmi_rxactive_i` rising during TA or HS is ignored; the handshake still completes.

## Timing
- Reset values: all outputs 0, `frame_num_o` = 11'h000, state IDLE, disarmed.
  - Assertion of `usb_rst_i` mid-transfer drops `utmi_txvalid_o` immediately; no partial-strobe recovery.
- `sof_o` and `tok_o`: 1 cycle after the second token byte's rxvalid cycle.
- `rx_valid_o`: 1 cycle after the rxvalid of the payload byte two positions later; at most one strobe per cycle.
- `rx_done_o` / `rx_err_o`: the cycle after `utmi_rxactive_i` is sampled low.
- `utmi_txvalid_o`: rises exactly `TA_CYCLES` cycles after `rx_done_o`, with `utmi_data_out_o` stable. It is held until the cycle `utmi_txready_i` = 1 is sampled, then drops the next cycle.

## Test plan
- SOF: PID 0xA5, frame 0x123 with correct CRC5 → `sof_o` pulses and `frame_num_o` = 11'h123.
- Corrupt the CRC5 bit of the same SOF → no pulse; `frame_num_o` is unchanged.
- SETUP to address 0x05 EP0, then DATA0 with 8 bytes 00 01 .. 07 and correct CRC16:
  - 8 `rx_valid_o` strobes with bytes 00..07 in order.
  - `rx_done_o` pulses with `rx_data1_o` = 0.
  - ACK 0xD2 is driven exactly 16 cycles after `rx_done_o`.
- OUT to address 0x05 EP2 with `ep_rdy_i` = 0, then DATA1 with 4 bytes → `tok_ep_o` = 2, `rx_data1_o` = 1, handshake NAK 0x5A.
- OUT to address 0x06 while `dev_addr_i` = 0x05, then DATA0 → no `tok_o`, no strobes, no handshake.
- Good OUT, then DATA0 with one flipped CRC16 bit → `rx_err_o` pulses and `utmi_txvalid_o` stays 0.
- Good OUT, then a 65-byte payload → `rx_err_o` pulses, no handshake.
- `usb_rst_i` asserted during HS → `utmi_txvalid_o` drops to 0 immediately.
